// File: rtl/rv32_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// rv32_wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback stage and out-of-order long-latency completions (mul/div today,
// iterative FPU ops later). Completions that cannot write immediately wait in
// a small in-order queue. The pipeline normally wins the port. A queued head
// that has lost MAX_DEFER arbitrations in a row is forced through, and the
// pipeline is stalled for that cycle.
//
// Parameters
//   QDEPTH     completion queue depth (power of 2, >= 2)
//   MAX_DEFER  arbitrations a non-empty head may lose before it is forced (>= 1)
//
// Ports
//   clk_i, rst_n_i           clock, synchronous active-low reset
//   pipe_we_i/fp_i/rd_i/data_i  pipeline writeback request
//   stall_pipe_o             pipeline request not granted; M/W must hold
//   lc_valid_i/rd_i/data_i   long-latency completion (integer file only)
//   lc_ready_o               completion accepted this cycle
//   rf_we_o, rf_fp_we_o      integer / FP file write enables
//   rf_rd_o, rf_data_o       write address / data (combinational from grant)
//   rs1_d_i, rs2_d_i         decode source registers for the pending check
//   pend_hit_o               a source matches a live queued destination
//   q_count_o                occupied queue entries (live and dead)
//   perf_conflict_o          cycles with pipe_we_i and a non-empty queue
//   perf_stall_o             cycles with stall_pipe_o asserted
//
// Optional feature
//   RV32_WB_ARB_PERF_EN      when defined, the two perf counters are built;
//                            otherwise both perf outputs are tied to zero.
// -----------------------------------------------------------------------------
module rv32_wb_port_arbiter #(
    parameter int QDEPTH    = 2,
    parameter int MAX_DEFER = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      pipe_we_i,
    input  logic                      pipe_fp_i,
    input  logic [4:0]                pipe_rd_i,
    input  logic [31:0]               pipe_data_i,
    output logic                      stall_pipe_o,
    input  logic                      lc_valid_i,
    input  logic [4:0]                lc_rd_i,
    input  logic [31:0]               lc_data_i,
    output logic                      lc_ready_o,
    output logic                      rf_we_o,
    output logic                      rf_fp_we_o,
    output logic [4:0]                rf_rd_o,
    output logic [31:0]               rf_data_o,
    input  logic [4:0]                rs1_d_i,
    input  logic [4:0]                rs2_d_i,
    output logic                      pend_hit_o,
    output logic [$clog2(QDEPTH):0]   q_count_o,
    output logic [31:0]               perf_conflict_o,
    output logic [31:0]               perf_stall_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(MAX_DEFER + 1);
    localparam logic [CW-1:0] QDEPTH_C    = CW'(QDEPTH);
    localparam logic [DW-1:0] MAX_DEFER_C = DW'(MAX_DEFER);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_HEAD,
        GRANT_PIPE,
        GRANT_BYPASS
    } grant_e;

    // Queue storage; pointers carry one extra bit so full and empty differ.
    logic [QDEPTH-1:0] q_live;
    logic [4:0]        q_rd   [QDEPTH];
    logic [31:0]       q_data [QDEPTH];
    logic [CW-1:0]     wr_ptr;
    logic [CW-1:0]     rd_ptr;
    logic [DW-1:0]     defer;

    logic [CW-1:0] q_count;
    logic          q_empty;
    logic          q_full;
    logic [AW-1:0] head_idx;
    logic [AW-1:0] tail_idx;

    grant_e        grant;
    logic          push;
    logic          pop;
    logic          kill_en;
    logic          stall;
    logic          pend_hit;
    logic          wr_we;
    logic          wr_fp_we;
    logic [4:0]    wr_rd;
    logic [31:0]   wr_data;

    assign q_count  = wr_ptr - rd_ptr;
    assign q_empty  = (q_count == '0);
    assign q_full   = (q_count == QDEPTH_C);
    assign head_idx = rd_ptr[AW-1:0];
    assign tail_idx = wr_ptr[AW-1:0];

    // Grant priority: forced head, pipeline, voluntary head, bypass.
    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = GRANT_NONE;
        if (!q_empty && (defer == MAX_DEFER_C)) begin
            grant = GRANT_HEAD;
        end else if (pipe_we_i) begin
            grant = GRANT_PIPE;
        end else if (!q_empty) begin
            grant = GRANT_HEAD;
        end else if (lc_valid_i) begin
            grant = GRANT_BYPASS;
        end
    end

    assign pop   = (grant == GRANT_HEAD);
    assign stall = pop && pipe_we_i;
    // Readiness uses the registered count only: a same-cycle pop never frees a
    // slot for that cycle's push. Completions to x0 are accepted and dropped.
    assign push  = lc_valid_i && !q_full && (grant != GRANT_BYPASS) && (lc_rd_i != 5'd0);
    // A granted integer pipeline write is younger than anything queued for
    // the same register, so the queued copies must never reach the file.
    assign kill_en = (grant == GRANT_PIPE) && !pipe_fp_i && (pipe_rd_i != 5'd0);

    // Write-port mux.
    always_comb begin
        wr_we    = 1'b0;
        wr_fp_we = 1'b0;
        wr_rd    = 5'd0;
        wr_data  = 32'd0;
        case (grant)
            GRANT_HEAD: begin
                wr_we   = q_live[head_idx];
                wr_rd   = q_rd[head_idx];
                wr_data = q_data[head_idx];
            end
            GRANT_PIPE: begin
                wr_we    = !pipe_fp_i && (pipe_rd_i != 5'd0);
                wr_fp_we = pipe_fp_i;
                wr_rd    = pipe_rd_i;
                wr_data  = pipe_data_i;
            end
            GRANT_BYPASS: begin
                wr_we   = (lc_rd_i != 5'd0);
                wr_rd   = lc_rd_i;
                wr_data = lc_data_i;
            end
            default: ;
        endcase
    end

    // Pending-destination check for decode, including a completion being
    // enqueued this very cycle.
    always_comb begin
        pend_hit = push && ((lc_rd_i == rs1_d_i) || (lc_rd_i == rs2_d_i));
        for (int i = 0; i < QDEPTH; i++) begin
            if (q_live[i] && (q_rd[i] != 5'd0) &&
                ((q_rd[i] == rs1_d_i) || (q_rd[i] == rs2_d_i))) begin
                pend_hit = 1'b1;
            end
        end
    end

    // Control state: pointers, live bits and the defer counter.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            defer  <= '0;
            q_live <= '0;
        end else begin
            if (pop) begin
                rd_ptr           <= rd_ptr + 1'b1;
                q_live[head_idx] <= 1'b0;
                defer            <= '0;
            end else if ((grant == GRANT_PIPE) && !q_empty && (defer != MAX_DEFER_C)) begin
                defer <= defer + 1'b1;
            end

            if (kill_en) begin
                for (int i = 0; i < QDEPTH; i++) begin
                    if (q_rd[i] == pipe_rd_i) begin
                        q_live[i] <= 1'b0;
                    end
                end
            end

            // The tail slot is never occupied when pushing, so this set may
            // safely override a kill that matched its stale rd.
            if (push) begin
                wr_ptr           <= wr_ptr + 1'b1;
                q_live[tail_idx] <= 1'b1;
            end
        end
    end

    // NOTE: the rd/data payload is not reset; an entry is only ever observed
    // through its live bit and the pointers, which are reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_rd[tail_idx]   <= lc_rd_i;
            q_data[tail_idx] <= lc_data_i;
        end
    end

    // Outputs are held at their reset values while reset is asserted so that
    // nothing is written to the register file during a reset cycle.
    assign rf_we_o      = rst_n_i && wr_we;
    assign rf_fp_we_o   = rst_n_i && wr_fp_we;
    assign rf_rd_o      = rst_n_i ? wr_rd   : 5'd0;
    assign rf_data_o    = rst_n_i ? wr_data : 32'd0;
    assign stall_pipe_o = rst_n_i && stall;
    assign lc_ready_o   = rst_n_i ? !q_full : 1'b1;
    assign pend_hit_o   = rst_n_i && pend_hit;
    assign q_count_o    = rst_n_i ? q_count : '0;

`ifdef RV32_WB_ARB_PERF_EN
    logic [31:0] perf_conflict;
    logic [31:0] perf_stall;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            perf_conflict <= 32'd0;
            perf_stall    <= 32'd0;
        end else begin
            if (pipe_we_i && !q_empty) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
            if (stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end

    assign perf_conflict_o = rst_n_i ? perf_conflict : 32'd0;
    assign perf_stall_o    = rst_n_i ? perf_stall    : 32'd0;
`else
    assign perf_conflict_o = 32'd0;
    assign perf_stall_o    = 32'd0;
`endif

endmodule

// File: tb/tb_rv32_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rv32_wb_port_arbiter
//
// Directed scenarios plus a randomized run checked against a queue-based
// behavioural model of the write-port arbiter. Inputs change on the falling
// edge; outputs are compared 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_rv32_wb_port_arbiter;

    localparam int QDEPTH    = 2;
    localparam int MAX_DEFER = 4;
    localparam int CW        = $clog2(QDEPTH) + 1;
    localparam int VW        = 106 + CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pipe_we, pipe_fp;
    logic [4:0]    pipe_rd;
    logic [31:0]   pipe_data;
    logic          stall_pipe_o;
    logic          lc_valid;
    logic [4:0]    lc_rd;
    logic [31:0]   lc_data;
    logic          lc_ready_o;
    logic          rf_we_o, rf_fp_we_o;
    logic [4:0]    rf_rd_o;
    logic [31:0]   rf_data_o;
    logic [4:0]    rs1, rs2;
    logic          pend_hit_o;
    logic [CW-1:0] q_count_o;
    logic [31:0]   perf_conflict_o, perf_stall_o;

    always #5 clk = ~clk;

    rv32_wb_port_arbiter #(.QDEPTH(QDEPTH), .MAX_DEFER(MAX_DEFER)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .pipe_we_i       (pipe_we),
        .pipe_fp_i       (pipe_fp),
        .pipe_rd_i       (pipe_rd),
        .pipe_data_i     (pipe_data),
        .stall_pipe_o    (stall_pipe_o),
        .lc_valid_i      (lc_valid),
        .lc_rd_i         (lc_rd),
        .lc_data_i       (lc_data),
        .lc_ready_o      (lc_ready_o),
        .rf_we_o         (rf_we_o),
        .rf_fp_we_o      (rf_fp_we_o),
        .rf_rd_o         (rf_rd_o),
        .rf_data_o       (rf_data_o),
        .rs1_d_i         (rs1),
        .rs2_d_i         (rs2),
        .pend_hit_o      (pend_hit_o),
        .q_count_o       (q_count_o),
        .perf_conflict_o (perf_conflict_o),
        .perf_stall_o    (perf_stall_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Integer register file as written by the DUT.
    logic [31:0] dut_rf [32];

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit       live;
        bit [4:0] rd;
        bit [31:0] data;
    } ent_t;

    typedef enum {K_NONE, K_HEAD, K_PIPE, K_BYP} kind_e;

    ent_t        mq[$];
    int          mdefer;
    int unsigned m_conf, m_stall;
    kind_e       mk;

    logic        e_we, e_fp_we, e_stall, e_ready, e_pend, e_push;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_pc, e_ps;
    int          e_count;

    function automatic void model_eval();
        bit empty;
        bit full;
        e_we = 0; e_fp_we = 0; e_rd = 0; e_data = 0; e_stall = 0;
        e_ready = 1; e_pend = 0; e_push = 0; e_count = 0; e_pc = 0; e_ps = 0;
        mk = K_NONE;
        if (!rst_n) return;
        empty = (mq.size() == 0);
        full  = (mq.size() == QDEPTH);
        if (!empty && mdefer == MAX_DEFER)  mk = K_HEAD;
        else if (pipe_we)                   mk = K_PIPE;
        else if (!empty)                    mk = K_HEAD;
        else if (lc_valid)                  mk = K_BYP;
        case (mk)
            K_HEAD: begin
                e_we = mq[0].live; e_rd = mq[0].rd; e_data = mq[0].data;
                e_stall = pipe_we;
            end
            K_PIPE: begin
                e_we = !pipe_fp && pipe_rd != 0; e_fp_we = pipe_fp;
                e_rd = pipe_rd; e_data = pipe_data;
            end
            K_BYP: begin
                e_we = (lc_rd != 0); e_rd = lc_rd; e_data = lc_data;
            end
            default: ;
        endcase
        e_ready = !full;
        e_push  = lc_valid && e_ready && mk != K_BYP && lc_rd != 0;
        foreach (mq[i])
            if (mq[i].live && mq[i].rd != 0 && (mq[i].rd == rs1 || mq[i].rd == rs2))
                e_pend = 1;
        if (e_push && (lc_rd == rs1 || lc_rd == rs2)) e_pend = 1;
        e_count = mq.size();
`ifdef RV32_WB_ARB_PERF_EN
        e_pc = m_conf;
        e_ps = m_stall;
`endif
    endfunction

    function automatic void model_commit();
        if (!rst_n) begin
            mq.delete(); mdefer = 0; m_conf = 0; m_stall = 0;
            return;
        end
        if (pipe_we && mq.size() != 0) m_conf++;
        if (e_stall) m_stall++;
        if (mk == K_HEAD) begin
            void'(mq.pop_front());
            mdefer = 0;
        end else if (mk == K_PIPE && mq.size() != 0 && mdefer < MAX_DEFER) begin
            mdefer++;
        end
        if (mk == K_PIPE && !pipe_fp && pipe_rd != 0)
            foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].live = 0;
        if (e_push) mq.push_back('{1'b1, lc_rd, lc_data});
    endfunction

    // ---------------- sequencing helpers ----------------
    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic adv();
        model_eval();
        if (rf_we_o) dut_rf[rf_rd_o] = rf_data_o;
        model_commit();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pipe_we = 0; pipe_fp = 0; pipe_rd = 0; pipe_data = 0;
        lc_valid = 0; lc_rd = 0; lc_data = 0; rs1 = 0; rs2 = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        settle();
        n_total++;
        if ({rf_we_o, rf_fp_we_o, rf_rd_o, rf_data_o, stall_pipe_o, lc_ready_o, pend_hit_o} !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_outputs: got we=%b fpwe=%b rd=%0d data=%h stall=%b rdy=%b pend=%b want 0 0 0 0 0 1 0",
                     rf_we_o, rf_fp_we_o, rf_rd_o, rf_data_o, stall_pipe_o, lc_ready_o, pend_hit_o);
        else n_pass++;
        adv();
        rst_n = 1;
        settle();
        n_total++;
        if ({q_count_o, lc_ready_o, rf_we_o} !== {CW'(0), 1'b1, 1'b0})
            $display("FAIL reset_state: got count=%0d rdy=%b we=%b want 0 1 0", q_count_o, lc_ready_o, rf_we_o);
        else n_pass++;
        n_total++;
        if ({perf_conflict_o, perf_stall_o} !== 64'd0)
            $display("FAIL reset_perf: got %h/%h want 0/0", perf_conflict_o, perf_stall_o);
        else n_pass++;
        adv();
    endtask

    task automatic test_bypass();
        idle_inputs();
        lc_valid = 1; lc_rd = 5; lc_data = 32'h1234;
        settle();
        n_total++;
        if ({rf_we_o, rf_fp_we_o, rf_rd_o, rf_data_o, lc_ready_o} !== {1'b1, 1'b0, 5'd5, 32'h1234, 1'b1})
            $display("FAIL bypass_write: got we=%b fpwe=%b rd=%0d data=%h rdy=%b want 1 0 5 00001234 1",
                     rf_we_o, rf_fp_we_o, rf_rd_o, rf_data_o, lc_ready_o);
        else n_pass++;
        adv();
        idle_inputs();
        settle();
        n_total++;
        if (q_count_o !== CW'(0))
            $display("FAIL bypass_count: got %0d want 0", q_count_o);
        else n_pass++;
        n_total++;
        if (dut_rf[5] !== 32'h1234)
            $display("FAIL bypass_x5: got %h want 00001234", dut_rf[5]);
        else n_pass++;
        adv();
    endtask

    task automatic test_defer_limit();
        idle_inputs();
        pipe_we = 1; pipe_rd = 1; pipe_data = 32'h100;
        lc_valid = 1; lc_rd = 7; lc_data = 32'h7777; rs1 = 7;
        settle();
        n_total++;
        if ({rf_we_o, rf_rd_o, stall_pipe_o, pend_hit_o} !== {1'b1, 5'd1, 1'b0, 1'b1})
            $display("FAIL defer_enqueue: got we=%b rd=%0d stall=%b pend=%b want 1 1 0 1",
                     rf_we_o, rf_rd_o, stall_pipe_o, pend_hit_o);
        else n_pass++;
        adv();
        lc_valid = 0;
        for (int i = 0; i < MAX_DEFER; i++) begin
            pipe_data = 32'h101 + i;
            settle();
            n_total++;
            if ({rf_we_o, rf_rd_o, rf_data_o, stall_pipe_o, q_count_o} !== {1'b1, 5'd1, 32'h101 + i, 1'b0, CW'(1)})
                $display("FAIL defer_pipe_win%0d: got we=%b rd=%0d data=%h stall=%b count=%0d want 1 1 %h 0 1",
                         i, rf_we_o, rf_rd_o, rf_data_o, stall_pipe_o, q_count_o, 32'h101 + i);
            else n_pass++;
            adv();
        end
        pipe_data = 32'h200;
        settle();
        n_total++;
        if ({rf_we_o, rf_rd_o, rf_data_o, stall_pipe_o} !== {1'b1, 5'd7, 32'h7777, 1'b1})
            $display("FAIL defer_forced: got we=%b rd=%0d data=%h stall=%b want 1 7 00007777 1",
                     rf_we_o, rf_rd_o, rf_data_o, stall_pipe_o);
        else n_pass++;
        adv();
        settle();
        n_total++;
        if ({rf_we_o, rf_rd_o, rf_data_o, stall_pipe_o, q_count_o} !== {1'b1, 5'd1, 32'h200, 1'b0, CW'(0)})
            $display("FAIL defer_after: got we=%b rd=%0d data=%h stall=%b count=%0d want 1 1 00000200 0 0",
                     rf_we_o, rf_rd_o, rf_data_o, stall_pipe_o, q_count_o);
        else n_pass++;
        adv();
        idle_inputs();
    endtask

    task automatic test_waw_kill();
        idle_inputs();
        pipe_we = 1; pipe_rd = 3; pipe_data = 32'h33;
        lc_valid = 1; lc_rd = 9; lc_data = 32'hAAAA;
        settle();
        adv();
        lc_valid = 0; pipe_rd = 9; pipe_data = 32'hBBBB; rs1 = 9;
        settle();
        n_total++;
        if (pend_hit_o !== 1'b1)
            $display("FAIL waw_pend_before: got %b want 1", pend_hit_o);
        else n_pass++;
        n_total++;
        if ({rf_we_o, rf_rd_o, rf_data_o} !== {1'b1, 5'd9, 32'hBBBB})
            $display("FAIL waw_pipe_write: got we=%b rd=%0d data=%h want 1 9 0000bbbb", rf_we_o, rf_rd_o, rf_data_o);
        else n_pass++;
        adv();
        pipe_we = 0;
        settle();
        n_total++;
        if ({pend_hit_o, q_count_o, rf_we_o} !== {1'b0, CW'(1), 1'b0})
            $display("FAIL waw_dead_drain: got pend=%b count=%0d we=%b want 0 1 0", pend_hit_o, q_count_o, rf_we_o);
        else n_pass++;
        adv();
        settle();
        n_total++;
        if ({q_count_o, dut_rf[9]} !== {CW'(0), 32'hBBBB})
            $display("FAIL waw_final: got count=%0d x9=%h want 0 0000bbbb", q_count_o, dut_rf[9]);
        else n_pass++;
        adv();
        idle_inputs();
    endtask

    task automatic test_full();
        logic [4:0]  src_rd[3]   = '{5'd11, 5'd12, 5'd13};
        logic [31:0] src_data[3] = '{32'h1111, 32'h2222, 32'h3333};
        logic [36:0] popped[$];
        int          src_idx = 0;
        int          acc3 = -1;
        idle_inputs();
        pipe_we = 1; pipe_rd = 1; pipe_data = 32'h55;
        for (int c = 0; c < 20; c++) begin
            if (src_idx < 3) begin
                lc_valid = 1; lc_rd = src_rd[src_idx]; lc_data = src_data[src_idx];
            end else begin
                lc_valid = 0;
            end
            settle();
            if (c == 2 || c == 5) begin
                n_total++;
                if (lc_ready_o !== 1'b0)
                    $display("FAIL full_ready_c%0d: got %b want 0", c, lc_ready_o);
                else n_pass++;
            end
            if (stall_pipe_o && rf_we_o) popped.push_back({rf_rd_o, rf_data_o});
            if (lc_valid && lc_ready_o) begin
                if (src_idx == 2) acc3 = c;
                src_idx++;
            end
            adv();
        end
        idle_inputs();
        n_total++;
        if (acc3 != 6)
            $display("FAIL full_third_accept: got cycle %0d want 6", acc3);
        else n_pass++;
        n_total++;
        if (popped.size() != 3)
            $display("FAIL full_pop_count: got %0d want 3", popped.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < popped.size(); i++) begin
            n_total++;
            if (popped[i] !== {src_rd[i], src_data[i]})
                $display("FAIL full_order%0d: got %h want %h", i, popped[i], {src_rd[i], src_data[i]});
            else n_pass++;
        end
    endtask

    task automatic test_x0();
        idle_inputs();
        lc_valid = 1; lc_rd = 0; lc_data = 32'hDEAD;
        settle();
        n_total++;
        if ({rf_we_o, rf_fp_we_o, lc_ready_o} !== 3'b001)
            $display("FAIL x0_bypass: got we=%b fpwe=%b rdy=%b want 0 0 1", rf_we_o, rf_fp_we_o, lc_ready_o);
        else n_pass++;
        adv();
        pipe_we = 1; pipe_fp = 0; pipe_rd = 0; pipe_data = 32'hF00;
        lc_valid = 1; lc_rd = 0; lc_data = 32'hBEEF;
        settle();
        n_total++;
        if ({rf_we_o, rf_fp_we_o, lc_ready_o} !== 3'b001)
            $display("FAIL x0_pipe_int: got we=%b fpwe=%b rdy=%b want 0 0 1", rf_we_o, rf_fp_we_o, lc_ready_o);
        else n_pass++;
        adv();
        pipe_fp = 1; lc_valid = 0;
        settle();
        n_total++;
        if ({rf_we_o, rf_fp_we_o, rf_rd_o, rf_data_o, q_count_o} !== {1'b0, 1'b1, 5'd0, 32'hF00, CW'(0)})
            $display("FAIL x0_fp_f0: got we=%b fpwe=%b rd=%0d data=%h count=%0d want 0 1 0 00000f00 0",
                     rf_we_o, rf_fp_we_o, rf_rd_o, rf_data_o, q_count_o);
        else n_pass++;
        adv();
        idle_inputs();
    endtask

    task automatic test_random();
        bit lc_hold    = 0;
        bit last_stall = 0;
        logic [VW-1:0] dv, ev;
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if (!last_stall) begin
                pipe_we   = ($urandom_range(0, 99) < 60);
                pipe_fp   = ($urandom_range(0, 3) == 0);
                pipe_rd   = 5'($urandom_range(0, 7));
                pipe_data = $urandom;
            end
            if (!lc_hold) begin
                lc_valid = ($urandom_range(0, 99) < 50);
                lc_rd    = 5'($urandom_range(0, 7));
                lc_data  = $urandom;
            end
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            settle();
            dv = {rf_we_o, rf_fp_we_o, rf_rd_o, rf_data_o, stall_pipe_o, lc_ready_o,
                  pend_hit_o, q_count_o, perf_conflict_o, perf_stall_o};
            ev = {e_we, e_fp_we, e_rd, e_data, e_stall, e_ready,
                  e_pend, CW'(e_count), e_pc, e_ps};
            n_total++;
            if (dv !== ev)
                $display("FAIL random_cyc%0d: got %h want %h", i, dv, ev);
            else n_pass++;
            lc_hold    = rst_n && lc_valid && !e_ready;
            last_stall = e_stall;
            adv();
        end
        rst_n = 1;
        idle_inputs();
        for (int i = 0; i < 4; i++) adv();
    endtask

    task automatic test_reset_mid_drain();
        idle_inputs();
        pipe_we = 1; pipe_rd = 1; pipe_data = 32'h77;
        lc_valid = 1; lc_rd = 14; lc_data = 32'hE;
        settle();
        adv();
        lc_rd = 15; lc_data = 32'hF;
        settle();
        adv();
        lc_valid = 0;
        settle();
        n_total++;
        if (q_count_o !== CW'(2))
            $display("FAIL rst_drain_fill: got count=%0d want 2", q_count_o);
        else n_pass++;
        adv();
        pipe_we = 0; rst_n = 0;
        settle();
        n_total++;
        if (rf_we_o !== 1'b0)
            $display("FAIL rst_drain_no_write: got we=%b want 0", rf_we_o);
        else n_pass++;
        adv();
        rst_n = 1;
        settle();
        n_total++;
        if ({q_count_o, rf_we_o, lc_ready_o, perf_conflict_o, perf_stall_o} !== {CW'(0), 1'b0, 1'b1, 64'd0})
            $display("FAIL rst_drain_state: got count=%0d we=%b rdy=%b perf=%h/%h want 0 0 1 0/0",
                     q_count_o, rf_we_o, lc_ready_o, perf_conflict_o, perf_stall_o);
        else n_pass++;
        for (int i = 0; i < 3; i++) adv();
        n_total++;
        if ({dut_rf[14], dut_rf[15]} !== 64'd0)
            $display("FAIL rst_drain_discard: got x14=%h x15=%h want 0 0", dut_rf[14], dut_rf[15]);
        else n_pass++;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) dut_rf[r] = 32'd0;
        mdefer = 0; m_conf = 0; m_stall = 0;
        test_reset();
        test_bypass();
        test_defer_limit();
        test_waw_kill();
        test_full();
        test_x0();
        test_random();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv32_wb_port_arbiter.md
Name: rv32_wb_port_arbiter

Overview:
- Schedules the single integer/FP register-file write port between two sources:
  - the in-order pipeline writeback stage;
  - out-of-order long-latency completions (the mul/div unit now, FPU iterative ops later).
- Buffers completions in a small in-order queue and stalls the pipeline writeback only when a queued result has waited too long.
- Reports queued destination registers to the hazard unit so decode can interlock.

Parameters:
- QDEPTH, 2, completion queue depth in entries; power of 2, >= 2.
- MAX_DEFER, 4, cycles a non-empty queue head may lose arbitration before it is forced to win; >= 1.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- pipe_we_i  in  1  pipeline writeback write request
- pipe_fp_i  in  1  pipeline target is FP file (1) or integer file (0)
- pipe_rd_i  in  5  pipeline destination register
- pipe_data_i  in  32  pipeline write data
- stall_pipe_o  out  1  pipeline request not granted this cycle; M/W stages must hold
- lc_valid_i  in  1  long-latency completion valid (integer file only)
- lc_rd_i  in  5  completion destination
- lc_data_i  in  32  completion data
- lc_ready_o  out  1  completion accepted this cycle
- rf_we_o  out  1  integer file write enable
- rf_fp_we_o  out  1  FP file write enable
- rf_rd_o  out  5  write address
- rf_data_o  out  32  write data
- rs1_d_i  in  5  decode rs1, pending check
- rs2_d_i  in  5  decode rs2, pending check
- pend_hit_o  out  1  rs1/rs2 (nonzero) matches a live queued rd
- q_count_o  out  $clog2(QDEPTH)+1  live+dead entries in queue
- perf_conflict_o  out  32  see Optional Feature
- perf_stall_o  out  32  see Optional Feature

Behaviour:
- One clock domain: clk_i. Reset is synchronous and active-low on rst_n_i.
- Reset:
  - queue empty;
  - defer counter = 0;
  - all rf_*_o = 0;
  - stall_pipe_o = 0;
  - lc_ready_o = 1;
  - pend_hit_o = 0;
  - perf counters = 0.
- Reset mid-operation discards all queued entries with no writes issued.
- Queue: circular FIFO. Each entry holds {live, rd[4:0], data[31:0]}. Wrap pointers carry an extra MSB to distinguish full from empty.
- Write outputs are combinational from the grant mux (zero added latency). Queue, pointers and counters update on the rising clock edge.
- Grant decision, one per cycle, in priority order:
  1. Head forced: queue non-empty and defer == MAX_DEFER. Head drives the port; stall_pipe_o = pipe_we_i.
  2. Pipeline: pipe_we_i = 1. Pipeline drives the port. Head stays; defer += 1 if queue non-empty, saturating.
  3. Head: queue non-empty and pipe_we_i = 0. Head drives the port; defer <= 0.
  4. Bypass: queue empty, pipe_we_i = 0, lc_valid_i = 1. Completion drives the port directly and is not enqueued.
- Head grant of a dead entry: dequeue with rf_we_o = 0. It still counts as the grant, and defer resets.
- Enqueue:
  - lc_valid_i & lc_ready_o & not bypassed pushes {1, lc_rd_i, lc_data_i}.
  - lc_ready_o = !full, computed from the registered count. A same-cycle dequeue does not free a slot for that cycle's push.
  - When lc_ready_o = 0 the completion source holds lc_* stable.
- Sources targeting register 0:
  - Integer rd == 0 from either source: rf_we_o = 0. Completions to x0 are accepted and dropped, never enqueued.
  - FP f0 is a real register and is written normally.
- WAW ordering: a granted integer pipeline write to rd != 0 clears live on every queued entry with the same rd in that cycle. The younger value must not be overwritten later.
- pend_hit_o:
  - OR over live entries of (rd == rs1_d_i | rd == rs2_d_i), excluding rd == 0.
  - Also includes a same-cycle lc_valid_i that is being enqueued (not bypassed).
- Simultaneous push and pop when full: the pop happens, the push is refused (lc_ready_o was 0).
- Count and pointers never overflow or underflow. Push and pop of the same entry in one cycle is impossible: a push only targets the tail when not full.

Optional Feature:
- Macro: RV32_WB_ARB_PERF_EN.
- Defined:
  - perf_conflict_o increments each cycle pipe_we_i and a non-empty queue coexist.
  - perf_stall_o increments each cycle stall_pipe_o = 1.
  - Both are 32-bit, wrap at 2^32, and are cleared by reset.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized. Arbitration is identical either way.

Test Plan:
1. Bypass: queue empty, pipe_we_i = 0, lc_valid_i = 1, rd = 5, data = 0x1234 → same-cycle rf_we_o = 1, rf_rd_o = 5, rf_data_o = 0x1234; q_count_o stays 0.
2. Defer limit: MAX_DEFER = 4; enqueue rd = 7 while pipe_we_i = 1 continuously → pipeline granted 4 cycles. Cycle 5: rf_rd_o = 7, stall_pipe_o = 1. Cycle 6: pipeline granted again.
3. WAW kill: queue rd = 9 data = 0xAAAA, then pipeline write rd = 9 data = 0xBBBB → later head drain gives rf_we_o = 0; final x9 = 0xBBBB; pend_hit_o for rs1 = 9 drops once the entry is killed.
4. Full: QDEPTH = 2, pipe_we_i held 1, three lc_valid_i completions → lc_ready_o = 0 on the third until a forced pop. The third is accepted the cycle after the pop, with no data loss and order preserved.
5. Writes to x0: lc_valid_i rd = 0 and pipe_fp_i = 0 rd = 0 → rf_we_o = 0 and no enqueue. pipe_fp_i = 1 rd = 0 → rf_fp_we_o = 1.
6. Reset mid-drain: two live entries, then rst_n_i = 0 for 1 cycle → next cycle q_count_o = 0, rf_we_o = 0, lc_ready_o = 1, perf counters = 0.
